// File: rtl/upscaler_pkg.sv
// Shared types for the upscaler stream blocks: pixel width, pixel type and
// the frame-tracking states used by the source selector.
package upscaler_pkg;

    localparam int PIX_W = 24;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        BOUNDARY,
        IN_FRAME,
        DRAIN
    } mux_state_e;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-stage valid/ready pipeline register. Accepts a new beat whenever the
// stage is empty or being drained, so it sustains one beat per cycle.
module stream_reg_slice #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Payload only moves on an accepted beat; it is held while stalled or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_stream_mux.sv
// N-input pixel stream selector. Source switches are deferred to frame
// boundaries so an output frame never mixes pixels from two sources.
module pixel_stream_mux
    import upscaler_pkg::*;
#(
    parameter int  DATA_W = PIX_W,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel_req,
    input  logic                     sel_req_valid,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     switch_pending,
    output logic                     sel_err
);

    mux_state_e       state_reg;
    logic [SEL_W-1:0] active_sel_reg;
    logic [SEL_W-1:0] pending_sel_reg;
    logic             switch_pending_reg;
    logic             sel_err_reg;

    logic [DATA_W-1:0] ch_data [NUM_IN];
    logic              cur_valid;
    logic              cur_last;
    logic [DATA_W-1:0] cur_data;
    logic              slice_ready;
    logic [DATA_W:0]   slice_q;
    logic              accept;
    logic              sel_in_range;
    logic              req_legal;
    logic              req_is_active;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
            assign in_ready[gi] = slice_ready && (active_sel_reg == SEL_W'(gi));
        end

        // With a power-of-two channel count every encodable index is valid.
        if ((1 << SEL_W) == NUM_IN) begin : g_range_full
            assign sel_in_range = 1'b1;
        end else begin : g_range_cmp
            assign sel_in_range = (sel_req < SEL_W'(NUM_IN));
        end
    endgenerate

    assign cur_valid     = in_valid[active_sel_reg];
    assign cur_last      = in_last[active_sel_reg];
    assign cur_data      = ch_data[active_sel_reg];
    assign accept        = cur_valid && slice_ready;
    assign req_legal     = sel_req_valid && sel_in_range;
    assign req_is_active = (sel_req == active_sel_reg);

    stream_reg_slice #(
        .W (DATA_W + 1)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (cur_valid),
        .in_data   ({cur_last, cur_data}),
        .in_ready  (slice_ready),
        .out_valid (out_valid),
        .out_data  (slice_q),
        .out_ready (out_ready)
    );

    assign out_last       = slice_q[DATA_W];
    assign out_data       = slice_q[DATA_W-1:0];
    assign active_sel     = active_sel_reg;
    assign switch_pending = switch_pending_reg;
    assign sel_err        = sel_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= BOUNDARY;
            active_sel_reg     <= '0;
            pending_sel_reg    <= '0;
            switch_pending_reg <= 1'b0;
            sel_err_reg        <= 1'b0;
        end else begin
            sel_err_reg <= sel_req_valid && !sel_in_range;

            case (state_reg)
                BOUNDARY: begin
                    // A frame opening this cycle belongs to the old source, so a
                    // simultaneous request to a different source must wait.
                    if (accept && !cur_last) begin
                        if (req_legal && !req_is_active) begin
                            state_reg          <= DRAIN;
                            pending_sel_reg    <= sel_req;
                            switch_pending_reg <= 1'b1;
                        end else begin
                            state_reg <= IN_FRAME;
                        end
                    end else if (req_legal) begin
                        active_sel_reg <= sel_req;
                    end
                end

                IN_FRAME: begin
                    if (accept && cur_last) begin
                        state_reg <= BOUNDARY;
                        if (req_legal) begin
                            active_sel_reg <= sel_req;
                        end
                    end else if (req_legal && !req_is_active) begin
                        state_reg          <= DRAIN;
                        pending_sel_reg    <= sel_req;
                        switch_pending_reg <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (accept && cur_last) begin
                        state_reg          <= BOUNDARY;
                        switch_pending_reg <= 1'b0;
                        active_sel_reg     <= req_legal ? sel_req : pending_sel_reg;
                    end else if (req_legal) begin
                        if (req_is_active) begin
                            state_reg          <= IN_FRAME;
                            switch_pending_reg <= 1'b0;
                        end else begin
                            pending_sel_reg <= sel_req;
                        end
                    end
                end

                default: begin
                    state_reg          <= BOUNDARY;
                    switch_pending_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_mux.sv
// Self-checking bench for pixel_stream_mux: reference model on a 4-input
// instance, vector table, directed corner sequences and random traffic.
module tb_pixel_stream_mux;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int N5 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [1:0]     sel_req;
    logic           sel_req_valid;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     active_sel;
    logic           switch_pending;
    logic           sel_err;

    logic [2:0]      sel_req5;
    logic            sel_req_valid5;
    logic [N5-1:0]   in_valid5;
    logic [N5*W-1:0] in_data5;
    logic [N5-1:0]   in_last5;
    logic [N5-1:0]   in_ready5;
    logic            out_valid5;
    logic [W-1:0]    out_data5;
    logic            out_last5;
    logic            out_ready5;
    logic [2:0]      active_sel5;
    logic            switch_pending5;
    logic            sel_err5;

    pixel_stream_mux #(.DATA_W(W), .NUM_IN(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_req_valid(sel_req_valid),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .active_sel(active_sel),
        .switch_pending(switch_pending), .sel_err(sel_err)
    );

    pixel_stream_mux #(.DATA_W(W), .NUM_IN(N5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req5), .sel_req_valid(sel_req_valid5),
        .in_valid(in_valid5), .in_data(in_data5), .in_last(in_last5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_last(out_last5),
        .out_ready(out_ready5), .active_sel(active_sel5),
        .switch_pending(switch_pending5), .sel_err(sel_err5)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: frame flag, routed channel, pending request, output register.
    int          m_active;
    int          m_pending;
    bit          m_in_frame;
    bit          m_ov;
    bit          m_ol;
    logic [W-1:0] m_od;

    typedef struct {
        bit           sv;
        logic [1:0]   sr;
        logic [N-1:0] iv;
        logic [N-1:0] il;
        bit           ordy;
        bit           e_ov;
        bit           e_ol;
        logic [W-1:0] e_od;
        logic [1:0]   e_act;
        bit           e_sp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_pending  = -1;
        m_in_frame = 0;
        m_ov       = 0;
        m_ol       = 0;
        m_od       = '0;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        in_data[c*W +: W] = v;
    endtask

    task automatic idle_inputs();
        sel_req        = '0;
        sel_req_valid  = 1'b0;
        in_valid       = '0;
        in_last        = '0;
        in_data        = '0;
        out_ready      = 1'b1;
        sel_req5       = '0;
        sel_req_valid5 = 1'b0;
        in_valid5      = '0;
        in_last5       = '0;
        in_data5       = '0;
        out_ready5     = 1'b1;
    endtask

    // Advance one clock, update the model from the pre-edge inputs, compare.
    task automatic tick();
        bit   rdy;
        bit   acc;
        bit   lst;
        bit   frame_open;
        int   target;
        logic [N-1:0] exp_rdy;
        rdy = !m_ov || out_ready;
        acc = in_valid[m_active] && rdy;
        lst = in_last[m_active];
        target = sel_req_valid ? int'(sel_req) : m_pending;
        frame_open = acc ? !lst : m_in_frame;
        @(posedge clk);
        #1;
        if (acc) begin
            m_ov = 1;
            m_od = in_data[m_active*W +: W];
            m_ol = lst;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (!frame_open) begin
            if (target >= 0) m_active = target;
            m_pending = -1;
        end else begin
            m_pending = (target == m_active) ? -1 : target;
        end
        m_in_frame = frame_open;
        exp_rdy = (!m_ov || out_ready) ? (N'(1) << m_active) : '0;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_last", out_last, m_ol);
        chk("active_sel", active_sel, m_active);
        chk("switch_pending", switch_pending, m_pending >= 0);
        chk("sel_err", sel_err, 0);
        chk("in_ready", in_ready, exp_rdy);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_active_sel", active_sel, 0);
        chk("rst_switch_pending", switch_pending, 0);
        chk("rst_sel_err", sel_err, 0);

        // Four-beat frame on channel 0
        for (int b = 1; b <= 4; b++) begin
            set_ch(0, W'(b));
            in_valid = 4'b0001;
            in_last  = (b == 4) ? 4'b0001 : 4'b0000;
            #1;
            chk("t1_in_ready_others", in_ready[3:1], 0);
            chk("t1_in_ready_ch0", in_ready[0], 1);
            tick();
            chk("t1_data", out_data, b);
            chk("t1_last", out_last, b == 4);
        end
        idle_inputs();
        tick();
        chk("t1_drained", out_valid, 0);

        // Vector table
        do_reset();
        tbl[0]  = '{0, 2'd0, 4'b0001, 4'b0000, 1, 1, 0, 24'h000011, 2'd0, 0};
        tbl[1]  = '{1, 2'd2, 4'b0001, 4'b0000, 1, 1, 0, 24'h000011, 2'd0, 1};
        tbl[2]  = '{0, 2'd0, 4'b0000, 4'b0000, 1, 0, 0, 24'h000011, 2'd0, 1};
        tbl[3]  = '{0, 2'd0, 4'b0001, 4'b0001, 1, 1, 1, 24'h000011, 2'd2, 0};
        tbl[4]  = '{0, 2'd0, 4'b0100, 4'b0000, 1, 1, 0, 24'hAA0000, 2'd2, 0};
        tbl[5]  = '{0, 2'd0, 4'b0001, 4'b0000, 1, 0, 0, 24'hAA0000, 2'd2, 0};
        tbl[6]  = '{1, 2'd2, 4'b0000, 4'b0000, 1, 0, 0, 24'hAA0000, 2'd2, 0};
        tbl[7]  = '{1, 2'd1, 4'b0100, 4'b0100, 1, 1, 1, 24'hAA0000, 2'd1, 0};
        tbl[8]  = '{0, 2'd0, 4'b0010, 4'b0000, 1, 1, 0, 24'h000022, 2'd1, 0};
        tbl[9]  = '{0, 2'd0, 4'b0010, 4'b0010, 0, 1, 0, 24'h000022, 2'd1, 0};
        tbl[10] = '{0, 2'd0, 4'b0010, 4'b0010, 1, 1, 1, 24'h000022, 2'd1, 0};
        tbl[11] = '{1, 2'd3, 4'b0000, 4'b0000, 1, 0, 1, 24'h000022, 2'd3, 0};
        set_ch(0, 24'h000011);
        set_ch(1, 24'h000022);
        set_ch(2, 24'hAA0000);
        set_ch(3, 24'h000033);
        for (int i = 0; i < 12; i++) begin
            sel_req_valid = tbl[i].sv;
            sel_req       = tbl[i].sr;
            in_valid      = tbl[i].iv;
            in_last       = tbl[i].il;
            out_ready     = tbl[i].ordy;
            tick();
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].e_ol);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("tbl%0d_active_sel", i), active_sel, tbl[i].e_act);
            chk($sformatf("tbl%0d_switch_pending", i), switch_pending, tbl[i].e_sp);
        end
        idle_inputs();
        tick();

        // Mid-frame switch request to channel 2, honoured after beat 8
        do_reset();
        for (int b = 1; b <= 8; b++) begin
            set_ch(0, 24'h000100 + W'(b));
            set_ch(2, 24'hAA0000);
            in_valid      = 4'b0101;
            in_last       = (b == 8) ? 4'b0001 : 4'b0000;
            sel_req_valid = (b == 3);
            sel_req       = 2'd2;
            tick();
            chk("t2_ch0_beat", out_data, 24'h000100 + W'(b));
            if (b >= 3 && b < 8) chk("t2_pending", switch_pending, 1);
        end
        chk("t2_active_after", active_sel, 2);
        chk("t2_pending_after", switch_pending, 0);
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        tick();
        chk("t2_ch2_first", out_data, 24'hAA0000);
        in_last = 4'b0100;
        tick();
        idle_inputs();
        tick();

        // Last request wins; then a cancelled switch
        in_valid = 4'b0100;
        tick();
        in_valid = '0;
        sel_req_valid = 1; sel_req = 2'd1;
        tick();
        chk("t3_pending_1", switch_pending, 1);
        sel_req = 2'd3;
        tick();
        chk("t3_active_held", active_sel, 2);
        sel_req_valid = 0;
        in_valid = 4'b0100; in_last = 4'b0100;
        tick();
        chk("t3_active_last_wins", active_sel, 3);
        chk("t3_pending_clear", switch_pending, 0);
        in_valid = 4'b1000; in_last = 4'b0000;
        tick();
        in_valid = '0;
        sel_req_valid = 1; sel_req = 2'd0;
        tick();
        chk("t3_pending_0", switch_pending, 1);
        sel_req = 2'd3;
        tick();
        chk("t3_cancelled", switch_pending, 0);
        sel_req_valid = 0;
        in_valid = 4'b1000; in_last = 4'b1000;
        tick();
        chk("t3_active_kept", active_sel, 3);
        idle_inputs();
        tick();

        // Back-pressure hold, then full-rate drain
        set_ch(3, 24'h123456);
        in_valid = 4'b1000;
        tick();
        chk("t4_first", out_data, 24'h123456);
        set_ch(3, 24'h123457);
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, 24'h123456);
            chk("t4_hold_ready", in_ready[3], 0);
        end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            in_last = (k == 3) ? 4'b1000 : 4'b0000;
            tick();
            chk("t4_stream", out_data, 24'h123457 + W'(k));
            chk("t4_stream_valid", out_valid, 1);
            set_ch(3, 24'h123458 + W'(k));
        end
        idle_inputs();
        tick();

        // Illegal index on a 5-input instance
        sel_req_valid5 = 1; sel_req5 = 3'd2;
        tick();
        chk("t5_active2", active_sel5, 2);
        sel_req_valid5 = 0; in_valid5 = 5'b00100;
        tick();
        chk("t5_beat", out_valid5, 1);
        in_valid5 = '0; sel_req_valid5 = 1; sel_req5 = 3'd4;
        tick();
        chk("t5_pending", switch_pending5, 1);
        sel_req5 = 3'd5;
        tick();
        chk("t5_err_pulse", sel_err5, 1);
        chk("t5_err_active", active_sel5, 2);
        chk("t5_err_pending", switch_pending5, 1);
        sel_req_valid5 = 0;
        tick();
        chk("t5_err_drop", sel_err5, 0);
        in_valid5 = 5'b00100; in_last5 = 5'b00100;
        tick();
        chk("t5_switched", active_sel5, 4);
        in_valid5 = '0; in_last5 = '0;
        sel_req_valid5 = 1; sel_req5 = 3'd6;
        tick();
        chk("t5_err_boundary", sel_err5, 1);
        chk("t5_active_kept", active_sel5, 4);
        sel_req_valid5 = 0;
        tick();
        chk("t5_err_drop2", sel_err5, 0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) set_ch(ch, W'($urandom));
            in_valid      = N'($urandom);
            in_last       = N'($urandom & $urandom);
            out_ready     = ($urandom_range(0, 3) != 0);
            sel_req_valid = ($urandom_range(0, 7) == 0);
            sel_req       = 2'($urandom_range(0, 3));
            tick();
        end

        // Asynchronous reset while draining
        do_reset();
        set_ch(0, 24'h0000C1);
        in_valid = 4'b0001;
        tick();
        out_ready = 0;
        sel_req_valid = 1; sel_req = 2'd1;
        tick();
        chk("t6_drain_pending", switch_pending, 1);
        chk("t6_held_valid", out_valid, 1);
        sel_req_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_active", active_sel, 0);
        chk("t6_async_pending", switch_pending, 0);
        chk("t6_async_data", out_data, 0);
        idle_inputs();
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
